// File: rtl/memory_stage_pkg.sv
// Shared types for the MEM pipeline stage: word/register aliases, the
// E/M and M/W pipeline bundles, and the data-bus request FSM states.
package memory_stage_pkg;

    typedef logic [31:0] u32;
    typedef logic [4:0]  u5;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } mem_state_e;

    typedef struct packed {
        logic valid;
        logic reg_write;
        logic mem_to_reg;
        logic mem_write;
        logic branch;
        logic zero;
        u32   alu_result;
        u32   write_data;
        u5    write_reg;
        u32   pc_branch;
    } e_m_reg_t;

    typedef struct packed {
        logic valid;
        logic reg_write;
        logic mem_to_reg;
        u32   alu_result;
        u32   read_data;
        u5    write_reg;
    } m_w_reg_t;

    function automatic logic word_aligned(input u32 addr);
        return addr[1:0] == 2'b00;
    endfunction

endpackage

// File: rtl/memory_stage_if.sv
// Word data bus between the MEM stage (master) and data memory (slave).
// Request fields stay stable from assertion until ack or forced completion.
interface memory_stage_if;
    import memory_stage_pkg::*;

    logic dreq_valid;
    logic dreq_write;
    u32   dreq_addr;
    u32   dreq_wdata;
    logic dresp_ack;
    u32   dresp_rdata;

    modport master (
        output dreq_valid, dreq_write, dreq_addr, dreq_wdata,
        input  dresp_ack, dresp_rdata
    );

    modport slave (
        input  dreq_valid, dreq_write, dreq_addr, dreq_wdata,
        output dresp_ack, dresp_rdata
    );

endinterface

// File: rtl/memory_stage_mem_req_fsm.sv
// Data-bus request sequencer: completes on ack, or forcibly after TIMEOUT-1 wait cycles.
// Zero-cycle completion when ack arrives with the request; stalls otherwise.
module mem_req_fsm
    import memory_stage_pkg::*;
#(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic memop,
    input  logic dresp_ack,
    output logic dreq_valid,
    output logic stall,
    output logic complete,
    output logic timeout
);
    localparam int CW = $clog2(TIMEOUT);

    mem_state_e    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          last_wait;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign last_wait = (state_q == WAIT) && (cnt_q == CW'(TIMEOUT - 1));

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        dreq_valid = memop;
        timeout    = memop & ~dresp_ack & last_wait;
        complete   = memop & (dresp_ack | last_wait);
        stall      = memop & ~complete;
        case (state_q)
            IDLE: begin
                if (memop && !dresp_ack) begin
                    state_d = WAIT;
                    cnt_d   = CW'(1);
                end
            end
            WAIT: begin
                // The M register is frozen while waiting, so memop only drops on completion.
                if (!memop || complete) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

endmodule

// File: rtl/memory_stage.sv
// MEM stage: registers E/M, runs word loads/stores on the data bus, resolves branches.
// One cycle E/M to M/W; upstream is stalled while a bus request awaits ack.
module memory_stage
    import memory_stage_pkg::*;
#(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic em_valid,
    input  logic em_reg_write,
    input  logic em_mem_to_reg,
    input  logic em_mem_write,
    input  logic em_branch,
    input  logic em_zero,
    input  u32   em_alu_result,
    input  u32   em_write_data,
    input  u5    em_write_reg,
    input  u32   em_pc_branch,
    memory_stage_if.master dbus,
    output logic stall,
    output logic pc_src,
    output u32   pc_branch,
    output u32   fwd_aluout,
    output u5    fwd_write_reg,
    output logic fwd_reg_write,
    output logic mw_valid,
    output logic mw_reg_write,
    output logic mw_mem_to_reg,
    output u32   mw_alu_result,
    output u32   mw_read_data,
    output u5    mw_write_reg,
    output logic bus_err,
    output logic misalign_err
);
    e_m_reg_t m_q;
    m_w_reg_t mw_q;
    logic     is_memop, memop, misaligned;
    logic     req_valid, complete, timeout, acked_load;
    logic     bus_err_q, misalign_err_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            m_q <= '0;
        end else if (!stall) begin
            m_q.valid      <= em_valid;
            m_q.reg_write  <= em_reg_write;
            m_q.mem_to_reg <= em_mem_to_reg;
            m_q.mem_write  <= em_mem_write;
            m_q.branch     <= em_branch;
            m_q.zero       <= em_zero;
            m_q.alu_result <= em_alu_result;
            m_q.write_data <= em_write_data;
            m_q.write_reg  <= em_write_reg;
            m_q.pc_branch  <= em_pc_branch;
        end
    end

    assign is_memop   = m_q.valid & (m_q.mem_to_reg | m_q.mem_write);
    assign memop      = is_memop & word_aligned(m_q.alu_result);
    assign misaligned = is_memop & ~word_aligned(m_q.alu_result);

    mem_req_fsm #(.TIMEOUT(TIMEOUT)) u_fsm (
        .clk        (clk),
        .reset      (reset),
        .memop      (memop),
        .dresp_ack  (dbus.dresp_ack),
        .dreq_valid (req_valid),
        .stall      (stall),
        .complete   (complete),
        .timeout    (timeout)
    );

    // A forced completion carries no data, so only acked loads capture rdata.
    assign acked_load = m_q.mem_to_reg & complete & ~timeout;

    always_ff @(posedge clk) begin
        if (reset) begin
            mw_q <= '0;
        end else if (!stall) begin
            mw_q.valid      <= m_q.valid;
            mw_q.reg_write  <= m_q.reg_write;
            mw_q.mem_to_reg <= m_q.mem_to_reg;
            mw_q.alu_result <= m_q.alu_result;
            mw_q.write_reg  <= m_q.write_reg;
            mw_q.read_data  <= acked_load ? dbus.dresp_rdata : '0;
        end else begin
            mw_q.valid     <= 1'b0;
            mw_q.reg_write <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bus_err_q      <= 1'b0;
            misalign_err_q <= 1'b0;
        end else begin
            bus_err_q      <= bus_err_q | timeout;
            misalign_err_q <= misalign_err_q | misaligned;
        end
    end

    assign dbus.dreq_valid = req_valid;
    assign dbus.dreq_write = m_q.mem_write;
    assign dbus.dreq_addr  = m_q.alu_result;
    assign dbus.dreq_wdata = m_q.write_data;

    assign pc_src        = m_q.valid & m_q.branch & m_q.zero;
    assign pc_branch     = m_q.pc_branch;
    assign fwd_aluout    = m_q.alu_result;
    assign fwd_write_reg = m_q.write_reg;
    assign fwd_reg_write = m_q.valid & m_q.reg_write;

    assign mw_valid      = mw_q.valid;
    assign mw_reg_write  = mw_q.reg_write;
    assign mw_mem_to_reg = mw_q.mem_to_reg;
    assign mw_alu_result = mw_q.alu_result;
    assign mw_read_data  = mw_q.read_data;
    assign mw_write_reg  = mw_q.write_reg;
    assign bus_err       = bus_err_q;
    assign misalign_err  = misalign_err_q;

endmodule

// File: tb/tb_memory_stage.sv
// Bench for memory_stage: directed scenarios with literal expectations, then random
// traffic checked each cycle against an instruction-level model with a latency-driven memory.
module tb_memory_stage;
    import memory_stage_pkg::*;

    localparam int TIMEOUT = 16;
    localparam int NEVER   = 1000;

    typedef struct {
        logic        valid, rw, mtr, mwr, br, zero;
        logic [31:0] alu, wdata, pcb, rdata;
        logic [4:0]  wreg;
        int          lat;
    } instr_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic        em_valid, em_reg_write, em_mem_to_reg, em_mem_write, em_branch, em_zero;
    logic [31:0] em_alu_result, em_write_data, em_pc_branch;
    logic [4:0]  em_write_reg;
    logic        stall, pc_src, fwd_reg_write, mw_valid, mw_reg_write, mw_mem_to_reg;
    logic [31:0] pc_branch, fwd_aluout, mw_alu_result, mw_read_data;
    logic [4:0]  fwd_write_reg, mw_write_reg;
    logic        bus_err, misalign_err;

    memory_stage_if dbus();

    memory_stage #(.TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset),
        .em_valid(em_valid), .em_reg_write(em_reg_write), .em_mem_to_reg(em_mem_to_reg),
        .em_mem_write(em_mem_write), .em_branch(em_branch), .em_zero(em_zero),
        .em_alu_result(em_alu_result), .em_write_data(em_write_data),
        .em_write_reg(em_write_reg), .em_pc_branch(em_pc_branch),
        .dbus(dbus),
        .stall(stall), .pc_src(pc_src), .pc_branch(pc_branch),
        .fwd_aluout(fwd_aluout), .fwd_write_reg(fwd_write_reg), .fwd_reg_write(fwd_reg_write),
        .mw_valid(mw_valid), .mw_reg_write(mw_reg_write), .mw_mem_to_reg(mw_mem_to_reg),
        .mw_alu_result(mw_alu_result), .mw_read_data(mw_read_data), .mw_write_reg(mw_write_reg),
        .bus_err(bus_err), .misalign_err(misalign_err)
    );

    int tests = 0;
    int fails = 0;

    // Model: instruction in M, cycles it has spent there, expected M/W contents and flags.
    instr_t      m, cur_em, pend, nop;
    int          elapsed;
    bit          held, accepted, rst_req, force_ack, spurious;
    logic        ev, erw, emtr, bus_e, mis_e;
    logic [31:0] ealu, erd;
    logic [4:0]  ewr;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic instr_t mk(input logic v, rw, mtr, mwr, br, z,
                                  input logic [31:0] alu, wd, pcb, input logic [4:0] wr,
                                  input int lat, input logic [31:0] rd);
        instr_t i;
        i.valid = v; i.rw = rw; i.mtr = mtr; i.mwr = mwr; i.br = br; i.zero = z;
        i.alu = alu; i.wdata = wd; i.pcb = pcb; i.wreg = wr; i.lat = lat; i.rdata = rd;
        return i;
    endfunction

    function automatic instr_t rnd();
        instr_t i;
        int k, r;
        i = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'($urandom_range(0, 1)),
               $urandom, $urandom, $urandom, 5'($urandom), 0, $urandom);
        i.valid = ($urandom_range(0, 7) != 0);
        k = $urandom_range(0, 3);
        case (k)
            0: i.rw = 1'b1;
            1: begin i.mtr = 1'b1; i.rw = 1'b1; end
            2: i.mwr = 1'b1;
            default: i.br = 1'b1;
        endcase
        if ((k == 1 || k == 2) && $urandom_range(0, 7) != 0) i.alu[1:0] = 2'b00;
        r = $urandom_range(0, 19);
        if (r < 8)       i.lat = 0;
        else if (r < 17) i.lat = r - 7;
        else if (r == 17) i.lat = TIMEOUT - 1;
        else if (r == 18) i.lat = TIMEOUT - 2;
        else             i.lat = NEVER;
        return i;
    endfunction

    task automatic drive_em(input instr_t i);
        em_valid = i.valid; em_reg_write = i.rw; em_mem_to_reg = i.mtr; em_mem_write = i.mwr;
        em_branch = i.br; em_zero = i.zero; em_alu_result = i.alu; em_write_data = i.wdata;
        em_write_reg = i.wreg; em_pc_branch = i.pcb;
    endtask

    task automatic model_reset();
        m = nop; elapsed = 0; held = 0;
        ev = 0; erw = 0; emtr = 0; ealu = 0; erd = 0; ewr = 0; bus_e = 0; mis_e = 0;
    endtask

    task automatic check_update();
        bit mem, ackv, to, est;
        mem  = m.valid && (m.mtr || m.mwr) && (m.alu[1:0] == 2'b00);
        ackv = mem && dbus.dresp_ack;
        to   = mem && !dbus.dresp_ack && (elapsed == TIMEOUT - 1);
        est  = mem && !(ackv || to);
        chk("stall", stall, est);
        chk("dreq_valid", dbus.dreq_valid, mem);
        if (mem) begin
            chk("dreq_write", dbus.dreq_write, m.mwr);
            chk("dreq_addr", dbus.dreq_addr, m.alu);
            chk("dreq_wdata", dbus.dreq_wdata, m.wdata);
        end
        chk("pc_src", pc_src, m.valid & m.br & m.zero);
        chk("pc_branch", pc_branch, m.pcb);
        chk("fwd_aluout", fwd_aluout, m.alu);
        chk("fwd_write_reg", fwd_write_reg, m.wreg);
        chk("fwd_reg_write", fwd_reg_write, m.valid & m.rw);
        chk("mw_valid", mw_valid, ev);
        chk("mw_reg_write", mw_reg_write, erw);
        if (ev) begin
            chk("mw_mem_to_reg", mw_mem_to_reg, emtr);
            chk("mw_alu_result", mw_alu_result, ealu);
            chk("mw_read_data", mw_read_data, erd);
            chk("mw_write_reg", mw_write_reg, ewr);
        end
        chk("bus_err", bus_err, bus_e);
        chk("misalign_err", misalign_err, mis_e);
        if (reset) begin
            model_reset();
        end else begin
            if (m.valid && (m.mtr || m.mwr) && m.alu[1:0] != 2'b00) mis_e = 1;
            if (to) bus_e = 1;
            if (est) begin
                ev = 0; erw = 0; elapsed++;
            end else begin
                ev = m.valid; erw = m.rw; emtr = m.mtr; ealu = m.alu; ewr = m.wreg;
                erd = (ackv && m.mtr) ? dbus.dresp_rdata : 32'h0;
                m = cur_em; elapsed = 0;
            end
            held = est;
        end
    endtask

    task automatic cycle();
        bit mem;
        @(posedge clk);
        #1;
        reset = rst_req; rst_req = 0;
        if (!held) begin cur_em = pend; drive_em(pend); accepted = 1; end
        else accepted = 0;
        mem = m.valid && (m.mtr || m.mwr) && (m.alu[1:0] == 2'b00);
        if (mem) begin
            dbus.dresp_ack   = (elapsed == m.lat);
            dbus.dresp_rdata = dbus.dresp_ack ? m.rdata : $urandom;
        end else begin
            dbus.dresp_ack   = force_ack || (spurious && $urandom_range(0, 1) == 1);
            dbus.dresp_rdata = $urandom;
        end
        force_ack = 0;
        @(negedge clk);
        check_update();
    endtask

    task automatic issue(input instr_t i);
        pend = i;
        for (int k = 0; k < 64; k++) begin
            cycle();
            if (accepted) break;
        end
        chk("issue_accepted", 32'(accepted), 32'd1);
        pend = nop;
    endtask

    task automatic drain();
        pend = nop;
        repeat (20) cycle();
    endtask

    initial begin
        int cnt;
        nop = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        pend = nop; cur_em = nop; rst_req = 0; force_ack = 0; spurious = 0; accepted = 0;
        model_reset();
        reset = 1'b1;
        drive_em(nop);
        dbus.dresp_ack = 1'b0; dbus.dresp_rdata = 32'h0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("rst_stall", stall, 0);          chk("rst_pc_src", pc_src, 0);
        chk("rst_pc_branch", pc_branch, 0);  chk("rst_fwd_aluout", fwd_aluout, 0);
        chk("rst_fwd_reg_write", fwd_reg_write, 0);
        chk("rst_mw_valid", mw_valid, 0);    chk("rst_mw_alu", mw_alu_result, 0);
        chk("rst_mw_rdata", mw_read_data, 0); chk("rst_mw_wreg", mw_write_reg, 0);
        chk("rst_bus_err", bus_err, 0);      chk("rst_misalign", misalign_err, 0);
        chk("rst_dreq_valid", dbus.dreq_valid, 0); chk("rst_dreq_addr", dbus.dreq_addr, 0);
        check_update();

        // ALU op passes through in two cycles without stalling.
        issue(mk(1, 1, 0, 0, 0, 0, 32'h10, 0, 0, 5'd3, 0, 0));
        cycle(); chk("alu_no_stall", stall, 0);
        cycle(); chk("alu_mw_alu", mw_alu_result, 32'h10);
        chk("alu_mw_wreg", mw_write_reg, 3); chk("alu_mw_valid", mw_valid, 1);

        // Load acked in the request cycle.
        issue(mk(1, 1, 1, 0, 0, 0, 32'h100, 0, 0, 5'd7, 0, 32'hCAFEBABE));
        cycle(); chk("ld_dreq_valid", dbus.dreq_valid, 1); chk("ld_dreq_write", dbus.dreq_write, 0);
        chk("ld_dreq_addr", dbus.dreq_addr, 32'h100); chk("ld_stall", stall, 0);
        cycle(); chk("ld_rdata", mw_read_data, 32'hCAFEBABE); chk("ld_dreq_drop", dbus.dreq_valid, 0);

        // Store acked after three wait cycles, with a follower queued upstream.
        issue(mk(1, 0, 0, 1, 0, 0, 32'h200, 32'h55, 0, 5'd0, 3, 0));
        pend = mk(1, 1, 0, 0, 0, 0, 32'h44, 0, 0, 5'd9, 0, 0);
        for (int k = 0; k < 3; k++) begin
            cycle(); chk("st_stall", stall, 1); chk("st_addr", dbus.dreq_addr, 32'h200);
            chk("st_wdata", dbus.dreq_wdata, 32'h55); chk("st_mw_bubble", mw_valid, 0);
        end
        pend = nop;
        cycle(); chk("st_release", stall, 0);
        cycle(); chk("st_mw_valid", mw_valid, 1); chk("st_follower_fwd", fwd_aluout, 32'h44);
        drain();

        // Load that is never acked: forced completion after TIMEOUT-1 stall cycles.
        issue(mk(1, 1, 1, 0, 0, 0, 32'h300, 0, 0, 5'd4, NEVER, 0));
        cnt = 0;
        for (int k = 0; k < 40; k++) begin
            cycle();
            if (stall) cnt++;
            else if (cnt > 0) break;
        end
        chk("to_stall_cycles", cnt, TIMEOUT - 1);
        cycle(); chk("to_bus_err", bus_err, 1); chk("to_rdata", mw_read_data, 0);
        chk("to_mw_valid", mw_valid, 1);
        repeat (3) cycle();
        chk("to_bus_err_sticky", bus_err, 1);

        // Misaligned load: no request, no stall, zero data.
        issue(mk(1, 1, 1, 0, 0, 0, 32'h102, 0, 0, 5'd5, 0, 32'h12345678));
        cycle(); chk("mis_dreq", dbus.dreq_valid, 0); chk("mis_stall", stall, 0);
        cycle(); chk("mis_err", misalign_err, 1); chk("mis_rdata", mw_read_data, 0);

        // Taken branch.
        issue(mk(1, 0, 0, 0, 1, 1, 0, 0, 32'h40, 0, 0, 0));
        cycle(); chk("br_pc_src", pc_src, 1); chk("br_target", pc_branch, 32'h40);

        // Reset while waiting on the bus; a late ack afterwards is ignored.
        drain();
        issue(mk(1, 1, 1, 0, 0, 0, 32'h400, 0, 0, 5'd6, NEVER, 0));
        cycle(); cycle(); chk("rw_waiting", stall, 1);
        rst_req = 1; cycle();
        force_ack = 1; cycle();
        chk("rw_dreq", dbus.dreq_valid, 0); chk("rw_stall", stall, 0);
        chk("rw_mw_valid", mw_valid, 0); chk("rw_mw_rw", mw_reg_write, 0);
        chk("rw_mw_alu", mw_alu_result, 0); chk("rw_mw_rdata", mw_read_data, 0);
        chk("rw_mw_wreg", mw_write_reg, 0); chk("rw_mw_mtr", mw_mem_to_reg, 0);
        chk("rw_bus_err", bus_err, 0); chk("rw_misalign", misalign_err, 0);

        // Random traffic with spurious acks while no request is outstanding.
        spurious = 1;
        for (int k = 0; k < 3000; k++) begin
            pend = rnd();
            cycle();
        end
        spurious = 0;
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
